// File: rtl/locker_access_ctrl.sv
// Sequencer in front of digital_locker: serializes a code MSB-first, reports the result,
// counts consecutive failures and enforces a timed lockout. Optional: AUTO_RELOCK_EN (OPEN timeout).
//
// state   | meaning
// IDLE    | ready for a code attempt
// SHIFT   | code bits driven onto lk_pwd_in, MSB first
// CHECK   | waiting CHECK_LAT cycles, then sampling lk_unlocked
// RESP    | one-cycle result pulse, failure count update
// OPEN    | locker held unlocked until close (or timeout)
// RELOCK  | one-cycle submit pulse to relock/clear the locker
// LOCKOUT | timed refusal after MAX_FAIL consecutive failures
module locker_access_ctrl #(
  parameter int PWD_W       = 4,
  parameter int CHECK_LAT   = 1,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter int OPEN_CYC    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [PWD_W-1:0]              code_in,
  input  logic                          close_req,
  output logic                          resp_valid,
  output logic                          resp_ok,
  output logic                          door_open,
  output logic                          lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic                          lk_pwd_in,
  output logic                          lk_submit,
  input  logic                          lk_unlocked
);

  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int M1   = (PWD_W > CHECK_LAT) ? PWD_W : CHECK_LAT;
  localparam int M2   = (M1 > LOCKOUT_CYC) ? M1 : LOCKOUT_CYC;
  localparam int CMAX = (M2 > OPEN_CYC) ? M2 : OPEN_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, CHECK, RESP, OPEN, RELOCK, LOCKOUT
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [PWD_W-1:0] sreg, sreg_nx;
  logic             ok, ok_nx;
  logic [FW-1:0]    fail_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sreg     <= '0;
      ok       <= 1'b0;
      fail_cnt <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sreg     <= sreg_nx;
      ok       <= ok_nx;
      fail_cnt <= fail_nx;
    end
  end

  // One shared down-counter serves shift length, check wait, lockout and open timeout.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sreg_nx    = sreg;
    ok_nx      = ok;
    fail_nx    = fail_cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_ok    = 1'b0;
    door_open  = 1'b0;
    lockout    = 1'b0;
    lk_pwd_in  = 1'b0;
    lk_submit  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          sreg_nx  = code_in;
          cnt_nx   = CW'(PWD_W - 1);
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        lk_pwd_in = sreg[PWD_W-1];
        sreg_nx   = sreg << 1;
        if (cnt == '0) begin
          cnt_nx   = CW'(CHECK_LAT - 1);
          state_nx = CHECK;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      CHECK: begin
        if (cnt == '0) begin
          ok_nx    = lk_unlocked;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_ok    = ok;
        if (ok) begin
          fail_nx  = '0;
`ifdef AUTO_RELOCK_EN
          cnt_nx   = CW'(OPEN_CYC - 1);
`endif
          state_nx = OPEN;
        end else begin
          if (fail_cnt != FW'(MAX_FAIL)) fail_nx = fail_cnt + FW'(1);
          state_nx = RELOCK;
        end
      end
      OPEN: begin
        door_open = 1'b1;
        if (close_req) begin
          state_nx = RELOCK;
        end
`ifdef AUTO_RELOCK_EN
        else if (cnt == '0) begin
          state_nx = RELOCK;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
`endif
      end
      RELOCK: begin
        lk_submit = 1'b1;
        if (fail_cnt == FW'(MAX_FAIL)) begin
          cnt_nx   = CW'(LOCKOUT_CYC - 1);
          state_nx = LOCKOUT;
        end else begin
          state_nx = IDLE;
        end
      end
      LOCKOUT: begin
        lockout = 1'b1;
        if (cnt == '0) begin
          fail_nx  = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_locker_access_ctrl.sv
// Bench for locker_access_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based reference model.
module tb_locker_access_ctrl;
  localparam int PWD_W       = 4;
  localparam int CHECK_LAT   = 1;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam int OPEN_CYC    = 32;
  localparam int RESP_D      = PWD_W + CHECK_LAT + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [PWD_W-1:0] code_in = '0;
  logic close_req = 1'b0;
  logic resp_valid, resp_ok, door_open, lockout;
  logic [1:0] fail_cnt;
  logic lk_pwd_in, lk_submit;
  logic lk_unlocked = 1'b0;

  locker_access_ctrl #(
    .PWD_W(PWD_W), .CHECK_LAT(CHECK_LAT), .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC), .OPEN_CYC(OPEN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .code_in(code_in), .close_req(close_req), .resp_valid(resp_valid),
    .resp_ok(resp_ok), .door_open(door_open), .lockout(lockout),
    .fail_cnt(fail_cnt), .lk_pwd_in(lk_pwd_in), .lk_submit(lk_submit),
    .lk_unlocked(lk_unlocked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each attempt is a timeline anchored at its acceptance cycle.
  int n = 0;
  bit m_idle = 1'b1, att = 1'b0, m_ok = 1'b0, m_open = 1'b0;
  int t_acc = -1000, t_rl = -1000, lock_end = -1000, open_start = -1000, m_fail = 0;
  logic [PWD_W-1:0] m_code = '0;

  task automatic model_reset();
    m_idle = 1'b1; att = 1'b0; m_ok = 1'b0; m_open = 1'b0;
    t_acc = -1000; t_rl = -1000; lock_end = -1000; open_start = -1000; m_fail = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int d;
      bit was_idle;
      was_idle = m_idle;
      if (m_open) begin
        bit timeout;
        timeout = 1'b0;
`ifdef AUTO_RELOCK_EN
        timeout = (n - open_start == OPEN_CYC - 1);
`endif
        if (close_req || timeout) begin
          m_open = 1'b0;
          t_rl = n + 1;
        end
      end
      if (att) begin
        d = n - t_acc;
        if (d == PWD_W + CHECK_LAT) m_ok = lk_unlocked;
        else if (d == RESP_D) begin
          att = 1'b0;
          if (m_ok) begin
            m_fail = 0; m_open = 1'b1; open_start = n + 1;
          end else begin
            if (m_fail < MAX_FAIL) m_fail++;
            t_rl = n + 1;
          end
        end
      end
      if (n == t_rl) begin
        if (m_fail == MAX_FAIL) lock_end = n + LOCKOUT_CYC;
        else m_idle = 1'b1;
      end
      if (n == lock_end) begin
        m_fail = 0; m_idle = 1'b1;
      end
      if (was_idle && req_valid) begin
        m_idle = 1'b0; att = 1'b1; t_acc = n; m_code = code_in;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int d;
      logic e_pwd, e_rv, e_ok, e_lo;
      e_pwd = 1'b0; e_rv = 1'b0; e_ok = 1'b0;
      if (att) begin
        d = n - t_acc;
        if (d >= 1 && d <= PWD_W) e_pwd = m_code[PWD_W-d];
        if (d == RESP_D) begin e_rv = 1'b1; e_ok = m_ok; end
      end
      e_lo = (n > lock_end - LOCKOUT_CYC) && (n <= lock_end);
      chk("m_req_ready", req_ready, m_idle);
      chk("m_lk_pwd_in", lk_pwd_in, e_pwd);
      chk("m_resp_valid", resp_valid, e_rv);
      chk("m_resp_ok", resp_ok, e_ok);
      chk("m_door_open", door_open, m_open);
      chk("m_lk_submit", lk_submit, (n == t_rl) ? 1 : 0);
      chk("m_lockout", lockout, e_lo);
      chk("m_fail_cnt", fail_cnt, m_fail);
    end
  end

  // Directed attempt: lk_unlocked carries the wanted result only in the CHECK cycle.
  task automatic do_attempt(input logic [3:0] code, input bit unl, input int exp_fail);
    logic [3:0] got;
    got = '0;
    @(negedge clk);
    chk("acc_ready", req_ready, 1);
    req_valid = 1'b1; code_in = code; lk_unlocked = !unl;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0; code_in = ~code;
      lk_unlocked = (k == 5) ? unl : !unl;
      if (k <= 4) begin
        got = {got[2:0], lk_pwd_in};
        chk("pwd_bit", lk_pwd_in, code[4-k]);
      end
      if (k == 4) chk("pwd_seq", got, code);
      if (k == 6) begin
        chk("resp_valid_at6", resp_valid, 1);
        chk("resp_ok", resp_ok, unl);
      end else begin
        chk("resp_valid_idle", resp_valid, 0);
      end
      if (k == 7) begin
        if (unl) begin
          chk("door_open", door_open, 1);
          chk("fail_cnt_ok", fail_cnt, 0);
        end else begin
          chk("submit_fail", lk_submit, 1);
          chk("fail_cnt_fail", fail_cnt, exp_fail);
        end
      end
      if (k == 8 && !unl) begin
        if (exp_fail == MAX_FAIL) chk("lockout_on", lockout, 1);
        else chk("ready_after_fail", req_ready, 1);
      end
    end
  endtask

  task automatic close_door();
    @(negedge clk);
    close_req = 1'b1;
    @(negedge clk);
    close_req = 1'b0;
    chk("close_submit", lk_submit, 1);
    chk("close_door_low", door_open, 0);
    @(negedge clk);
    chk("close_submit_once", lk_submit, 0);
    chk("close_ready", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pwd"}, lk_pwd_in, 0);
    chk({tag, "_door"}, door_open, 0);
    chk({tag, "_submit"}, lk_submit, 0);
    chk({tag, "_rv"}, resp_valid, 0);
    chk({tag, "_lockout"}, lockout, 0);
    chk({tag, "_fail"}, fail_cnt, 0);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic quiet_after_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_submit", lk_submit, 0);
      chk("post_rst_rv", resp_valid, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    do_attempt(4'b1100, 1'b1, 0);
    close_door();

    do_attempt(4'b1010, 1'b0, 1);
    do_attempt(4'b0110, 1'b0, 2);
    do_attempt(4'b0001, 1'b0, 3);
    lo = 1;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      chk("lockout_no_resp", resp_valid, 0);
      if (!lockout) break;
      lo++;
      req_valid = (i <= 4); code_in = 4'b1100;
    end
    req_valid = 1'b0;
    chk("lockout_len", lo, LOCKOUT_CYC);
    chk("lockout_fail_clr", fail_cnt, 0);
    chk("lockout_ready", req_ready, 1);

    do_attempt(4'b1111, 1'b0, 1);
    do_attempt(4'b0000, 1'b0, 2);
    do_attempt(4'b1001, 1'b1, 0);
    chk("succ_no_lockout", lockout, 0);
    close_door();

    do_attempt(4'b0101, 1'b0, 1);
    @(negedge clk);
    req_valid = 1'b1; code_in = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_pwd", lk_pwd_in, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_shift");
    @(negedge clk);
    quiet_after_reset();

    do_attempt(4'b0011, 1'b1, 0);
    chk("pre_rst_door", door_open, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_open");
    @(negedge clk);
    quiet_after_reset();

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      req_valid   = $urandom_range(0, 1);
      code_in     = PWD_W'($urandom);
      close_req   = ($urandom_range(0, 5) == 0);
      lk_unlocked = $urandom_range(0, 1);
    end
    @(negedge clk);
    req_valid = 1'b0; close_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/locker_access_ctrl.md
Name: locker_access_ctrl

Overview:
- Sequencer in front of digital_locker: accepts a parallel code from a keypad/host front end and serializes it MSB-first onto the locker's pwd_in.
- Samples the locker's unlocked result and reports pass/fail.
- Drives submit to relock or clear the locker.
- Counts consecutive failures and enforces a timed lockout, so the locker is never driven directly by untrusted requesters.

Parameters:
- PWD_W, 4, code width in bits; also the number of serial shift cycles.
- CHECK_LAT, 1, cycles waited after the last bit before lk_unlocked is sampled; must be >= 1.
- MAX_FAIL, 3, consecutive failures that trigger lockout; must be >= 1.
- LOCKOUT_CYC, 16, lockout duration in clk cycles; must be >= 1.
- OPEN_CYC, 32, auto-relock timeout in cycles; used only when AUTO_RELOCK_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  code attempt request.
- req_ready  out  1  controller can accept a code.
- code_in  in  PWD_W  code; captured when req_valid && req_ready.
- close_req  in  1  level; relocks the locker when the door is open.
- resp_valid  out  1  one-cycle pulse carrying the attempt result.
- resp_ok  out  1  attempt result, qualified by resp_valid; 1 = unlocked.
- door_open  out  1  high while the locker is held unlocked.
- lockout  out  1  high during the lockout period.
- fail_cnt  out  $clog2(MAX_FAIL+1)  current consecutive failure count.
- lk_pwd_in  out  1  serial bit to locker pwd_in.
- lk_submit  out  1  one-cycle pulse to locker submit.
- lk_unlocked  in  1  locker unlocked output.

Behaviour:
- Reset values (asynchronous assert, synchronous-safe release):
  - state = IDLE.
  - All outputs = 0, except req_ready = 1.
  - fail_cnt = 0; shift register and counters = 0.
- States: IDLE, SHIFT, CHECK, RESP, OPEN, RELOCK, LOCKOUT.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch code_in, go to SHIFT.
  - req_ready is 0 in every other state.
- SHIFT (exactly PWD_W cycles):
  - lk_pwd_in = code bit PWD_W-1-k on the k-th SHIFT cycle, k = 0..PWD_W-1. The first bit appears the cycle after acceptance.
  - Then go to CHECK; lk_pwd_in returns to 0.
- CHECK:
  - Wait CHECK_LAT cycles, then sample lk_unlocked into an ok flag. Go to RESP.
- RESP (1 cycle):
  - resp_valid = 1, resp_ok = ok.
  - If ok: fail_cnt cleared to 0, go to OPEN.
  - If not ok: fail_cnt increments, saturating at MAX_FAIL; go to RELOCK.
- OPEN:
  - door_open = 1.
  - close_req = 1 -> RELOCK.
  - close_req is ignored in every other state.
- RELOCK (1 cycle):
  - lk_submit = 1; door_open = 0.
  - Next state is LOCKOUT if fail_cnt == MAX_FAIL, else IDLE.
- LOCKOUT:
  - lockout = 1; the counter loads LOCKOUT_CYC on entry and decrements each cycle.
  - When the counter reaches 0: fail_cnt cleared, lockout = 0, go to IDLE.
  - req_valid is ignored with no response.
- End-to-end latency: request accept to resp_valid = PWD_W + CHECK_LAT + 1 cycles.
- Boundary conditions:
  - req_valid held continuously: a new attempt starts only once back in IDLE.
  - Success after failures: fail_cnt resets to 0; lockout is never entered on a success.
  - lk_unlocked changing outside CHECK is ignored.
  - rst_n low mid-SHIFT or in OPEN: outputs drop immediately and no submit is generated. The locker's own reset is responsible for its state.

Optional Feature:
- Macro: AUTO_RELOCK_EN.
- Defined: OPEN also runs a counter loaded with OPEN_CYC on entry. At 0 the controller goes to RELOCK as if close_req had been asserted; close_req still relocks early.
- Undefined: OPEN persists until close_req; no timeout counter is synthesized.

Test Plan:
- Correct code: PWD_W=4, code_in=4'b1100 accepted.
  - lk_pwd_in = 1,1,0,0 on cycles 1..4 after acceptance.
  - Model asserts lk_unlocked -> resp_valid with resp_ok=1 at cycle 6; door_open=1.
  - close_req -> single lk_submit pulse, then IDLE.
- Wrong code 4'b1010 -> resp_ok=0, fail_cnt=1, lk_submit pulse, req_ready back to 1 one cycle later.
- Three consecutive wrong codes (MAX_FAIL=3):
  - Third response followed by lockout=1 for exactly 16 cycles.
  - A req_valid during lockout gets no resp_valid.
  - fail_cnt=0 after lockout ends.
- Two wrong codes then a correct one -> resp_ok=1, fail_cnt=0, no lockout.
- rst_n pulsed low during SHIFT bit 2 -> all outputs 0 asynchronously, req_ready=1 after release, no lk_submit pulse.
- AUTO_RELOCK_EN defined, OPEN_CYC=32 -> after a correct code, lk_submit pulses 32 cycles after door_open rises without close_req.
